// File: rtl/stage_two.sv
// TMDS stage two: turns a 9-bit transition-minimised word into a DC-balanced
// 10-bit symbol, tracking running disparity; emits control symbols when de = 0.
module stage_two #(
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [8:0] st2_in,
  input  logic       de,
  input  logic [1:0] ctrl,
  output logic [9:0] st2_out,
  output logic       de_out
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  logic signed [CNT_W-1:0] cnt, cnt_nxt;
  logic signed [CNT_W-1:0] diff;      // n1 - n0
  logic signed [CNT_W-1:0] two_b8;    // 2 * st2_in[8]
  logic signed [CNT_W-1:0] two_nb8;   // 2 * ~st2_in[8]
  logic [3:0]              n1;
  logic [9:0]              data_sym, ctrl_sym;
  logic                    b8;
  logic                    cnt_zero, cnt_pos, cnt_neg;

  assign b8 = st2_in[8];

  always_comb begin
    n1 = 4'd0;
    for (int i = 0; i < 8; i++)
      n1 = n1 + {3'd0, st2_in[i]};
  end

  // n1 - n0 = 2*n1 - 8; modular arithmetic keeps this exact in CNT_W bits
  assign diff    = $signed(CNT_W'({n1, 1'b0})) - $signed(CNT_W'(8));
  assign two_b8  = b8 ? $signed(CNT_W'(2)) : '0;
  assign two_nb8 = b8 ? '0 : $signed(CNT_W'(2));

  assign cnt_zero = (cnt == '0);
  assign cnt_neg  = cnt[CNT_W-1];
  assign cnt_pos  = !cnt_zero && !cnt_neg;

  always_comb begin
    data_sym = '0;
    cnt_nxt  = cnt;
    if (cnt_zero || n1 == 4'd4) begin
      data_sym = {~b8, b8, b8 ? st2_in[7:0] : ~st2_in[7:0]};
      cnt_nxt  = b8 ? cnt + diff : cnt - diff;
    end else if ((cnt_pos && n1 > 4'd4) || (cnt_neg && n1 < 4'd4)) begin
      data_sym = {1'b1, b8, ~st2_in[7:0]};
      cnt_nxt  = cnt + two_b8 - diff;
    end else begin
      data_sym = {1'b0, b8, st2_in[7:0]};
      cnt_nxt  = cnt + diff - two_nb8;
    end
  end

  always_comb begin
    case (ctrl)
      2'b00:   ctrl_sym = CTRL_00;
      2'b01:   ctrl_sym = CTRL_01;
      2'b10:   ctrl_sym = CTRL_10;
      default: ctrl_sym = CTRL_11;
    endcase
  end

  // Control periods also clear disparity so each data period starts balanced
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      st2_out <= CTRL_00;
      de_out  <= 1'b0;
      cnt     <= '0;
    end else begin
      de_out <= de;
      if (de) begin
        st2_out <= data_sym;
        cnt     <= cnt_nxt;
      end else begin
        st2_out <= ctrl_sym;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stage_two.sv
// Directed and randomised checks of stage_two against hand-computed symbols
// and an independent disparity model.
module tb_stage_two;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [8:0] st2_in;
  logic       de;
  logic [1:0] ctrl;
  logic [9:0] st2_out;
  logic       de_out;

  int checks = 0;
  int errors = 0;

  stage_two #(.CNT_W(5)) dut (
    .clk(clk), .n_rst(n_rst), .st2_in(st2_in), .de(de), .ctrl(ctrl),
    .st2_out(st2_out), .de_out(de_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model state
  int         mc;
  logic [9:0] mexp;

  task automatic model_step(input logic [8:0] d);
    int n1, n0;
    n1 = $countones(d[7:0]);
    n0 = 8 - n1;
    if (mc == 0 || n1 == n0) begin
      mexp = {~d[8], d[8], d[8] ? d[7:0] : ~d[7:0]};
      if (d[8]) mc = mc + n1 - n0;
      else      mc = mc + n0 - n1;
    end else if ((mc > 0 && n1 > n0) || (mc < 0 && n0 > n1)) begin
      mexp = {1'b1, d[8], ~d[7:0]};
      mc = mc + (d[8] ? 2 : 0) + n0 - n1;
    end else begin
      mexp = {1'b0, d[8], d[7:0]};
      mc = mc + n1 - n0 - (d[8] ? 0 : 2);
    end
  endtask

  initial begin
    n_rst = 1'b0; de = 1'b1; ctrl = 2'b11; st2_in = 9'h1FF;

    // reset overrides data inputs
    tick;
    chk10("reset_out", st2_out, 10'b1101010100);
    chk1 ("reset_de",  de_out, 1'b0);

    // all-zero data with XOR flag, twice: cnt 0 -> -8 -> +2
    n_rst = 1'b1; de = 1'b1; ctrl = 2'b01; st2_in = 9'b100000000;
    tick;
    chk10("zero_w1", st2_out, 10'b0100000000);
    chk1 ("zero_w1_de", de_out, 1'b1);
    tick;
    chk10("zero_w2", st2_out, 10'b1111111111);
    chk_int("zero_w2_cnt", int'(dut.cnt), 2);

    // fresh reset then XNOR word with five ones
    n_rst = 1'b0;
    tick;
    n_rst = 1'b1; st2_in = 9'b001111001; ctrl = 2'b10;
    tick;
    chk10("xnor_w", st2_out, 10'b1010000110);
    chk1 ("xnor_de", de_out, 1'b1);
    chk_int("xnor_cnt", int'(dut.cnt), -2);

    // control symbols; st2_in must be ignored
    de = 1'b0; st2_in = 9'b101010101;
    ctrl = 2'b00; tick; chk10("ctrl00", st2_out, 10'b1101010100); chk1("ctrl00_de", de_out, 1'b0);
    ctrl = 2'b01; tick; chk10("ctrl01", st2_out, 10'b0010101011); chk1("ctrl01_de", de_out, 1'b0);
    ctrl = 2'b10; tick; chk10("ctrl10", st2_out, 10'b0101010100); chk1("ctrl10_de", de_out, 1'b0);
    ctrl = 2'b11; tick; chk10("ctrl11", st2_out, 10'b1010101011); chk1("ctrl11_de", de_out, 1'b0);

    // burst leaves cnt = -8; one control cycle must clear it
    de = 1'b1; st2_in = 9'b100000000;
    tick; chk10("burst_w", st2_out, 10'b0100000000);
    de = 1'b0; ctrl = 2'b00;
    tick; chk10("gap_ctrl", st2_out, 10'b1101010100); chk1("gap_de", de_out, 1'b0);
    de = 1'b1; st2_in = 9'b100000000;
    tick; chk10("after_gap", st2_out, 10'b0100000000);

    // cnt = -8 here; a reset pulse must drop it
    n_rst = 1'b0; st2_in = 9'b100000000;
    tick;
    chk10("midrst_out", st2_out, 10'b1101010100);
    chk1 ("midrst_de",  de_out, 1'b0);
    n_rst = 1'b1;
    tick;
    chk10("post_rst", st2_out, 10'b0100000000);
    chk1 ("post_rst_de", de_out, 1'b1);

    // random data against the model
    n_rst = 1'b0; tick; n_rst = 1'b1;
    mc = 0; de = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      st2_in = 9'($urandom_range(0, 511));
      ctrl   = 2'($urandom_range(0, 3));
      model_step(st2_in);
      tick;
      chk10("rand_out", st2_out, mexp);
      chk_int("rand_cnt", int'(dut.cnt), mc);
      checks++;
      assert (mc >= -16 && mc <= 15) else begin
        errors++;
        $error("FAIL rand_range: observed %0d expected within [-16,15]", mc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
